icache_nway: RTL and testbench
==============================

# icache_nway

Parametrised N-way set-associative instruction cache with per-set FIFO (round-robin) replacement, single-clock synchronous design. Sits between the IFU and the L2 cache. Returns one full cache line per fetch request. Adds three things to the fixed 2-way cache: configurable geometry, a whole-cache invalidate (fence.i), and hit/miss counters.

## Interface
- PA_W, 34: physical address width
- LINE_BYTES, 32: line size in bytes; power of 2, ≥4
- SETS, 128: number of sets; power of 2, ≥2
- WAYS, 2: associativity; power of 2, ≥2
- Derived widths:
  - OFF_W = clog2(LINE_BYTES)
  - IDX_W = clog2(SETS)
  - TAG_W = PA_W−IDX_W−OFF_W
  - LINE_W = LINE_BYTES*8
- Address split: index = pa[OFF_W+IDX_W−1:OFF_W], tag = pa[PA_W−1:OFF_W+IDX_W]
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  IFU fetch request
- req_ready  out  1  request accepted when valid&&ready
- req_pa  in  PA_W  fetch physical address
- rsp_valid  out  1  line response
- rsp_ready  in  1  IFU accepts response
- rsp_data  out  LINE_W  line data
- rsp_hit  out  1  1 = served from cache, 0 = served from refill
- l2_req_valid  out  1  miss request
- l2_req_ready  in  1  L2 accepts miss request
- l2_req_pa  out  PA_W  line-aligned miss address (offset bits 0)
- l2_refill_valid  in  1  one-cycle refill beat carrying the full line
- l2_refill_data  in  LINE_W  refill line
- inv_valid  in  1  invalidate-all request
- inv_ready  out  1  invalidate accepted when valid&&ready
- hit_cnt  out  32  accepted requests that hit; wraps at 2^32
- miss_cnt  out  32  accepted requests that missed; wraps at 2^32

## Operation
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, INV.
- IDLE:
  - inv_ready = 1.
  - req_ready = !inv_valid. Invalidate has priority over a request in the same cycle.
  - On inv accept → INV.
  - On req accept: latch pa, read tag/valid/data arrays at index → LOOKUP.
- LOOKUP:
  - Compare latched tag against every way where valid=1. If more than one way matches, the lowest-numbered way wins.
  - Hit: register that way's data into rsp_data, rsp_hit=1, hit_cnt+1 → RESP.
  - Miss: miss_cnt+1 → MISS_REQ.
- MISS_REQ:
  - l2_req_valid=1, l2_req_pa = {tag, index, OFF_W'b0}; value held stable.
  - On l2_req_ready → MISS_WAIT.
- MISS_WAIT:
  - Wait for l2_refill_valid.
  - On refill: write data and tag into way victim = ptr[index], set valid, then ptr[index] = (ptr+1) mod WAYS.
  - rsp_data = refill data, rsp_hit=0 → RESP.
  - l2_refill_valid is ignored in every other state.
- RESP: rsp_valid=1; rsp_data and rsp_hit held stable until rsp_ready → IDLE.
- INV: clear all valid bits and all replacement pointers in one cycle → IDLE.
- Only one miss is outstanding at a time. No request is accepted outside IDLE.

## Timing
- Hit latency: request accepted at cycle T, rsp_valid asserted at T+2.
- Miss:
  - l2_req_valid asserted at T+2.
  - rsp_valid asserted the cycle after the refill beat.
- Invalidate: accepted at T, INV occupies T+1, back in IDLE at T+2.
- Reset values:
  - FSM returns to IDLE.
  - All outputs are 0 while rst is high: req_ready, inv_ready, rsp_valid, rsp_data, rsp_hit, l2_req_valid, l2_req_pa, hit_cnt, miss_cnt.
  - All valid bits and replacement pointers are cleared. Tag and data arrays are not reset.
- Reset mid-operation aborts any miss. A refill arriving after reset is ignored.
- Counters update in LOOKUP only, so each accepted request is counted exactly once.

## Structure
- Package icache_pkg holds:
  - state enum
  - clog2-derived width localparams, as functions of the parameters
  - line/tag typedefs
- Sub-module icache_way_array (one instance per way via generate):
  - tag and data storage with synchronous read
  - write enable
  - valid flop vector with synchronous clear-all
- Top level holds: FSM, replacement pointer array (SETS × clog2(WAYS)), compare/select logic, counters.

## Test plan
All scenarios use default parameters. Sets repeat every 0x1000.
- Cold miss then hit:
  - After rst, request 0x1000 → l2_req_pa=0x1000; refill D1 → rsp_data=D1, rsp_hit=0, miss_cnt=1.
  - Then request 0x1010 → rsp_valid at T+2, rsp_data=D1, rsp_hit=1, hit_cnt=1.
- Replacement:
  - Fill 0x1000 (way0), 0x2000 (way1), then 0x3000 (evicts way0).
  - Request 0x1000 → miss, evicts way1.
  - Request 0x3000 → hit. Request 0x2000 → miss.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and rsp_hit stay stable, req_ready=0 throughout. Response completes on the cycle rsp_ready rises.
- L2 stall: hold l2_req_ready=0 for 3 cycles → l2_req_valid=1 and l2_req_pa stay stable. A refill pulse during MISS_REQ is ignored.
- Invalidate:
  - Assert inv_valid and req_valid together in IDLE → inv accepted, req_ready=0; request accepted at T+2.
  - A previously cached 0x1000 then misses.
- Reset mid-miss: assert rst in MISS_WAIT → next cycle all outputs are 0. A later refill is ignored. Request 0x1000 then misses with miss_cnt=1.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESP,
        S_INV
    } state_t;

    function automatic int unsigned off_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned pa_w, input int unsigned line_bytes,
                                          input int unsigned sets);
        return pa_w - idx_w(sets) - off_w(line_bytes);
    endfunction

    function automatic int unsigned line_w(input int unsigned line_bytes);
        return line_bytes * 8;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned ways);
        return $clog2(ways);
    endfunction

    localparam int unsigned DEF_PA_W       = 34;
    localparam int unsigned DEF_LINE_BYTES = 32;
    localparam int unsigned DEF_SETS       = 128;
    localparam int unsigned DEF_TAG_W      = tag_w(DEF_PA_W, DEF_LINE_BYTES, DEF_SETS);
    localparam int unsigned DEF_LINE_W     = line_w(DEF_LINE_BYTES);

    typedef logic [DEF_LINE_W-1:0] line_t;
    typedef logic [DEF_TAG_W-1:0]  tag_t;

endpackage

// File: rtl/icache_way_array.sv
// One cache way: tag/data storage with synchronous read plus a clearable valid vector.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int unsigned SETS   = 128,
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned LINE_W = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     rd_en,
    input  logic [idx_w(SETS)-1:0]   rd_idx,
    input  logic                     wr_en,
    input  logic [idx_w(SETS)-1:0]   wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [LINE_W-1:0]        wr_data,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [LINE_W-1:0]        rd_data
);

    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];
    logic [SETS-1:0]   valid_bits;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag  <= tags[rd_idx];
            rd_data <= lines[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= valid_bits[rd_idx];
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with per-set round-robin replacement,
// whole-cache invalidate and hit/miss counters.
module icache_nway
    import icache_pkg::*;
#(
    parameter int unsigned PA_W       = 34,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned SETS       = 128,
    parameter int unsigned WAYS       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [PA_W-1:0]           req_pa,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [LINE_BYTES*8-1:0]   rsp_data,
    output logic                      rsp_hit,
    output logic                      l2_req_valid,
    input  logic                      l2_req_ready,
    output logic [PA_W-1:0]           l2_req_pa,
    input  logic                      l2_refill_valid,
    input  logic [LINE_BYTES*8-1:0]   l2_refill_data,
    input  logic                      inv_valid,
    output logic                      inv_ready,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
);

    localparam int unsigned OFF_W  = off_w(LINE_BYTES);
    localparam int unsigned IDX_W  = idx_w(SETS);
    localparam int unsigned TAG_W  = tag_w(PA_W, LINE_BYTES, SETS);
    localparam int unsigned LINE_W = line_w(LINE_BYTES);
    localparam int unsigned PTR_W  = ptr_w(WAYS);

    state_t state, state_nx;

    logic [PA_W-1:0]   pa_q;
    logic [IDX_W-1:0]  pa_idx;
    logic [TAG_W-1:0]  pa_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              req_fire;
    logic              refill_fire;
    logic [PTR_W-1:0]  ptr [SETS];
    logic [PTR_W-1:0]  victim;

    logic [WAYS-1:0]   way_valid;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_data [WAYS];
    logic              hit;
    logic [LINE_W-1:0] hit_data;

    assign pa_idx      = pa_q[OFF_W+IDX_W-1:OFF_W];
    assign pa_tag      = pa_q[PA_W-1:OFF_W+IDX_W];
    assign req_idx     = req_pa[OFF_W+IDX_W-1:OFF_W];
    assign victim      = ptr[pa_idx];
    assign req_fire    = req_valid && req_ready;
    assign refill_fire = (state == S_MISS_WAIT) && l2_refill_valid;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .clr      (state == S_INV),
            .rd_en    (req_fire),
            .rd_idx   (req_idx),
            .wr_en    (refill_fire && (victim == PTR_W'(w))),
            .wr_idx   (pa_idx),
            .wr_tag   (pa_tag),
            .wr_data  (l2_refill_data),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
    end

    // Scan from the top way down so the lowest-numbered matching way is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (way_valid[w-1] && (way_tag[w-1] == pa_tag)) begin
                hit      = 1'b1;
                hit_data = way_data[w-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (inv_valid)      state_nx = S_INV;
                else if (req_valid) state_nx = S_LOOKUP;
            end
            S_LOOKUP:    state_nx = hit ? S_RESP : S_MISS_REQ;
            S_MISS_REQ:  if (l2_req_ready) state_nx = S_MISS_WAIT;
            S_MISS_WAIT: if (l2_refill_valid) state_nx = S_RESP;
            S_RESP:      if (rsp_ready) state_nx = S_IDLE;
            S_INV:       state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs are gated by rst so they read 0 before the first reset edge lands.
    always_comb begin
        inv_ready    = !rst && (state == S_IDLE);
        req_ready    = !rst && (state == S_IDLE) && !inv_valid;
        rsp_valid    = !rst && (state == S_RESP);
        l2_req_valid = !rst && (state == S_MISS_REQ);
        l2_req_pa    = rst ? '0 : {pa_q[PA_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst || (state == S_INV)) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
            end
        end else if (refill_fire) begin
            ptr[pa_idx] <= victim + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pa_q     <= '0;
            rsp_data <= '0;
            rsp_hit  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (req_fire) begin
                pa_q <= req_pa;
            end
            if (state == S_LOOKUP) begin
                if (hit) begin
                    rsp_data <= hit_data;
                    rsp_hit  <= 1'b1;
                    hit_cnt  <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
            if (refill_fire) begin
                rsp_data <= l2_refill_data;
                rsp_hit  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway: directed table, corner sequences and a
// randomized run against a per-set FIFO queue model.
module tb_icache_nway;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [33:0]  req_pa;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_data;
    logic         rsp_hit;
    logic         l2_req_valid;
    logic         l2_req_ready;
    logic [33:0]  l2_req_pa;
    logic         l2_refill_valid;
    logic [255:0] l2_refill_data;
    logic         inv_valid;
    logic         inv_ready;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    icache_nway #(
        .PA_W       (34),
        .LINE_BYTES (32),
        .SETS       (128),
        .WAYS       (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pa          (req_pa),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_hit         (rsp_hit),
        .l2_req_valid    (l2_req_valid),
        .l2_req_ready    (l2_req_ready),
        .l2_req_pa       (l2_req_pa),
        .l2_refill_valid (l2_refill_valid),
        .l2_refill_data  (l2_refill_data),
        .inv_valid       (inv_valid),
        .inv_ready       (inv_ready),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: each set is a FIFO of resident lines, oldest first.
    typedef struct {
        logic [21:0]  tag;
        logic [255:0] data;
    } ent_t;

    ent_t        mq [128][$];
    logic [31:0] mh;
    logic [31:0] mm;

    task automatic model_clear();
        for (int s = 0; s < 128; s++) mq[s].delete();
    endtask

    task automatic model_access(input logic [33:0] pa, input logic [255:0] fill,
                                output logic hit, output logic [255:0] data);
        int s;
        logic [21:0] tag;
        s    = int'(pa[11:5]);
        tag  = pa[33:12];
        hit  = 1'b0;
        data = fill;
        for (int i = 0; i < mq[s].size(); i++) begin
            if (mq[s][i].tag == tag) begin
                hit  = 1'b1;
                data = mq[s][i].data;
            end
        end
        if (!hit) begin
            if (mq[s].size() == 2) void'(mq[s].pop_front());
            mq[s].push_back('{tag, fill});
        end
    endtask

    function automatic logic [255:0] fill_for(input logic [33:0] a);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = a[31:0] ^ (32'h9E3779B9 * 32'(k + 1));
        return v;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // One fetch: request, service the L2 side, optional response backpressure.
    task automatic fetch(input logic [33:0] pa, input logic [255:0] fill, input int bp,
                         input int stall, input bit junk,
                         output logic [255:0] data, output logic hit, output int lat,
                         output logic [33:0] l2pa, output bit saw, output int l2lat);
        bit hs, refilled, junk_sent;
        int stall_left;
        hs = 0; refilled = 0; junk_sent = 0; saw = 0; l2lat = 0; l2pa = '0;
        stall_left = stall;
        req_valid = 1'b1;
        req_pa    = pa;
        #1;
        check("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            if (l2_refill_valid) l2_refill_valid = 1'b0;
            if (l2_req_valid) begin
                if (!saw) begin
                    saw   = 1;
                    l2pa  = l2_req_pa;
                    l2lat = lat;
                end else begin
                    check("l2_pa_stable", l2_req_pa, l2pa);
                end
                if (stall_left > 0) begin
                    l2_req_ready = 1'b0;
                    stall_left--;
                    if (junk && !junk_sent) begin
                        l2_refill_valid = 1'b1;
                        l2_refill_data  = ~fill;
                        junk_sent = 1;
                    end
                end else begin
                    l2_req_ready = 1'b1;
                    hs = 1;
                end
            end else if (hs && !refilled) begin
                l2_req_ready    = 1'b0;
                l2_refill_valid = 1'b1;
                l2_refill_data  = fill;
                refilled = 1;
            end
            @(negedge clk);
            lat++;
        end
        l2_refill_valid = 1'b0;
        l2_req_ready    = 1'b0;
        check("rsp_valid_arrives", rsp_valid, 1'b1);
        data = rsp_data;
        hit  = rsp_hit;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data", rsp_data, data);
            check("bp_rsp_hit", rsp_hit, hit);
            check("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 1'b0);
    endtask

    task automatic run_access(input logic [33:0] pa, input logic [255:0] fill, input int bp,
                              input int stall, input bit junk, output logic got_hit);
        logic         eh;
        logic [255:0] ed;
        logic [255:0] d;
        int           lat, l2lat;
        logic [33:0]  l2pa;
        bit           saw;
        model_access(pa, fill, eh, ed);
        fetch(pa, fill, bp, stall, junk, d, got_hit, lat, l2pa, saw, l2lat);
        check("rsp_hit", got_hit, eh);
        check("rsp_data", d, ed);
        if (eh) begin
            mh++;
            check("hit_latency", lat, 2);
            check("hit_no_l2", saw, 1'b0);
        end else begin
            mm++;
            check("l2_req_pa", l2pa, {pa[33:5], 5'b0});
            check("l2_req_latency", l2lat, 2);
        end
        check("hit_cnt", hit_cnt, mh);
        check("miss_cnt", miss_cnt, mm);
    endtask

    task automatic do_inv(input logic with_req, input logic [33:0] pa);
        inv_valid = 1'b1;
        req_valid = with_req;
        req_pa    = pa;
        #1;
        check("inv_ready_idle", inv_ready, 1'b1);
        check("req_blocked_by_inv", req_ready, 1'b0);
        @(negedge clk);
        inv_valid = 1'b0;
        check("inv_state_inv_ready", inv_ready, 1'b0);
        check("inv_state_req_ready", req_ready, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        check("inv_back_idle", inv_ready, 1'b1);
        model_clear();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b0);
        check({tag, "_inv_ready"}, inv_ready, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_hit"}, rsp_hit, 1'b0);
        check({tag, "_l2_req_valid"}, l2_req_valid, 1'b0);
        check({tag, "_l2_req_pa"}, l2_req_pa, '0);
        check({tag, "_hit_cnt"}, hit_cnt, '0);
        check({tag, "_miss_cnt"}, miss_cnt, '0);
    endtask

    typedef struct {
        logic [33:0] pa;
        logic        hit;
        int unsigned hc;
        int unsigned mc;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [9];
        logic h;

        tbl[0] = '{34'h1000, 1'b0, 0, 1};
        tbl[1] = '{34'h1010, 1'b1, 1, 1};
        tbl[2] = '{34'h2000, 1'b0, 1, 2};
        tbl[3] = '{34'h3000, 1'b0, 1, 3};
        tbl[4] = '{34'h1000, 1'b0, 1, 4};
        tbl[5] = '{34'h3000, 1'b1, 2, 4};
        tbl[6] = '{34'h2000, 1'b0, 2, 5};
        tbl[7] = '{34'h101C, 1'b1, 3, 5};
        tbl[8] = '{34'h1020, 1'b0, 3, 6};

        rst = 1'b1; req_valid = 1'b0; req_pa = '0; rsp_ready = 1'b0;
        l2_req_ready = 1'b0; l2_refill_valid = 1'b0; l2_refill_data = '0; inv_valid = 1'b0;
        model_clear();
        mh = '0; mm = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_access(tbl[i].pa, fill_for({tbl[i].pa[33:5], 5'b0}), 0, 0, 0, h);
            check($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            check($sformatf("tbl%0d_hit_cnt", i), hit_cnt, tbl[i].hc);
            check($sformatf("tbl%0d_miss_cnt", i), miss_cnt, tbl[i].mc);
        end

        run_access(34'h1010, fill_for(34'h1000), 5, 0, 0, h);
        check("bp_seq_hit", h, 1'b1);

        run_access(34'h4020, fill_for(34'h4020), 0, 3, 1, h);
        check("stall_seq_miss", h, 1'b0);

        do_inv(1'b1, 34'h1000);
        run_access(34'h1000, fill_for(34'h1000), 0, 0, 0, h);
        check("after_inv_miss", h, 1'b0);

        req_valid = 1'b1; req_pa = 34'h5000; l2_req_ready = 1'b1;
        #1;
        check("rm_req_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rm_l2_req_valid", l2_req_valid, 1'b1);
        @(negedge clk);
        check("rm_in_wait", l2_req_valid, 1'b0);
        l2_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midmiss_rst");
        rst = 1'b0;
        @(negedge clk);
        l2_refill_valid = 1'b1;
        l2_refill_data  = fill_for(34'h5000);
        @(negedge clk);
        l2_refill_valid = 1'b0;
        check("late_refill_no_rsp", rsp_valid, 1'b0);
        check("late_refill_idle", req_ready, 1'b1);
        model_clear();
        mh = '0; mm = '0;
        run_access(34'h1000, fill_for(34'h1000), 0, 0, 0, h);
        check("post_rst_miss", h, 1'b0);
        check("post_rst_miss_cnt", miss_cnt, 32'd1);

        for (int i = 0; i < 250; i++) begin
            logic [33:0] pa;
            if ($urandom_range(0, 19) == 0) begin
                do_inv(1'($urandom_range(0, 1)), 34'h0);
            end
            pa = (34'($urandom_range(1, 6)) << 12) | (34'($urandom_range(0, 3)) << 5)
               | 34'($urandom_range(0, 31));
            run_access(pa, rand_line(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
